// File: rtl/address_register_file_p_pkg.sv
// Shared FunSel encodings, register index map and step helpers for the address register file.
// Latency: n/a (declarations only).
// Backpressure: n/a; the register file accepts an update on every clock.
package arf_pkg;

  // Function select shared by all enabled registers; 110/111 both mean hold.
  typedef enum logic [2:0] {
    FS_CLR   = 3'b000,
    FS_LD    = 3'b001,
    FS_INC   = 3'b010,
    FS_DEC   = 3'b011,
    FS_INC2  = 3'b100,
    FS_DEC2  = 3'b101,
    FS_HOLD  = 3'b110,
    FS_HOLD2 = 3'b111
  } funsel_e;

  localparam int IDX_PC = 0;
  localparam int IDX_AR = 1;
  localparam int IDX_SP = 2;

  // Magnitude of the inc/dec step; zero for non-arithmetic codes.
  function automatic logic [1:0] fs_step(input funsel_e fs);
    case (fs)
      FS_INC, FS_DEC:   return 2'd1;
      FS_INC2, FS_DEC2: return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

  function automatic logic fs_is_dec(input funsel_e fs);
    return (fs == FS_DEC) || (fs == FS_DEC2);
  endfunction

endpackage

// File: rtl/address_register_file_p_if.sv
// Bus bundle between the address-side control unit (master) and the register file (slave).
// Latency: writes land one clock after they are presented; reads are combinational.
// Backpressure: none; the slave accepts every cycle.
// Signals: I/FunSel/RegSel/ClrFlags = update request, OutCSel/OutDSel = read selects,
//          OutC/OutD = read data, WrapFlag/StackFault = sticky status.
interface address_register_file_p_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 3,
  parameter int SELW  = (NREG > 1) ? $clog2(NREG) : 1
);
  logic [WIDTH-1:0] I;
  logic [2:0]       FunSel;
  logic [NREG-1:0]  RegSel;
  logic [SELW-1:0]  OutCSel;
  logic [SELW-1:0]  OutDSel;
  logic             ClrFlags;
  logic [WIDTH-1:0] OutC;
  logic [WIDTH-1:0] OutD;
  logic [NREG-1:0]  WrapFlag;
  logic             StackFault;

  modport master (
    output I, FunSel, RegSel, OutCSel, OutDSel, ClrFlags,
    input  OutC, OutD, WrapFlag, StackFault
  );

  modport slave (
    input  I, FunSel, RegSel, OutCSel, OutDSel, ClrFlags,
    output OutC, OutD, WrapFlag, StackFault
  );
endinterface

// File: rtl/address_register_file_p_cell.sv
// One address register with its FunSel datapath (clear/load/+-1/+-2).
// Latency: q updates on the clock after we is high; nxt/wrap are combinational from q.
// Backpressure: none; the owner gates writes through we.
// Ports: clk/rst_n, we (commit nxt), funsel, din (load data), q (state), nxt (would-be value),
//        wrap (nxt wrapped modulo 2^WIDTH).
module addr_reg_cell
  import arf_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  funsel_e          funsel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] ext;

  // One extra bit catches carry out of inc and borrow out of dec alike.
  always_comb begin
    step_ext = {{(WIDTH-1){1'b0}}, fs_step(funsel)};
    ext      = fs_is_dec(funsel) ? ({1'b0, q} - step_ext) : ({1'b0, q} + step_ext);
    nxt      = q;
    wrap     = 1'b0;
    case (funsel)
      FS_CLR: nxt = '0;
      FS_LD:  nxt = din;
      FS_INC, FS_DEC, FS_INC2, FS_DEC2: begin
        nxt  = ext[WIDTH-1:0];
        wrap = ext[WIDTH];
      end
      default: nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST_VAL;
    else if (we) q <= nxt;
  end

endmodule

// File: rtl/address_register_file_p.sv
// NREG address registers (PC, AR, SP, general) with shared FunSel, sticky wrap flags and SP bounds fault.
// Latency: 1 clock for writes and flags; OutC/OutD are combinational from register state (no bypass).
// Backpressure: none; an SP inc/dec leaving [STACK_LO, SP_RST] is dropped and raises StackFault.
// Ports: Clock, ResetN (async active-low), bus (slave modport: I, FunSel, RegSel active-low mask,
//        OutCSel/OutDSel, ClrFlags in; OutC, OutD, WrapFlag, StackFault out).
module address_register_file_p
  import arf_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               NREG     = 3,
  parameter logic [WIDTH-1:0] PC_RST   = '0,
  parameter logic [WIDTH-1:0] SP_RST   = WIDTH'(16'hFFFF),
  parameter logic [WIDTH-1:0] STACK_LO = WIDTH'(16'hFF00)
) (
  input  logic                        Clock,
  input  logic                        ResetN,
  address_register_file_p_if.slave    bus
);

  localparam int SELW = (NREG > 1) ? $clog2(NREG) : 1;

  funsel_e          fs;
  logic [NREG-1:0]  en;
  logic [NREG-1:0]  we;
  logic [NREG-1:0]  wrap_v;
  logic [WIDTH-1:0] q   [NREG];
  logic [WIDTH-1:0] nxt [NREG];
  logic             sp_arith;
  logic             sp_oob;
  logic             sp_fault;
  logic [NREG-1:0]  wrap_q;
  logic             fault_q;
  logic [WIDTH-1:0] outc;
  logic [WIDTH-1:0] outd;

  assign fs = funsel_e'(bus.FunSel);
  assign en = ~bus.RegSel;

  // SP window check on the unwrapped result: a carry means it passed all-ones (>= SP_RST),
  // a borrow means it went below zero (< STACK_LO), otherwise compare the wrapped value.
  always_comb begin
    sp_arith = (fs_step(fs) != 2'd0);
    if (fs_is_dec(fs)) sp_oob = wrap_v[IDX_SP] || (nxt[IDX_SP] < STACK_LO);
    else               sp_oob = wrap_v[IDX_SP] || (nxt[IDX_SP] > SP_RST);
    sp_fault = en[IDX_SP] && sp_arith && sp_oob;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    localparam logic [WIDTH-1:0] RV = (i == IDX_PC) ? PC_RST :
                                      (i == IDX_SP) ? SP_RST : '0;
    if (i == IDX_SP) begin : g_sp
      assign we[i] = en[i] && !sp_fault;
    end else begin : g_gen
      assign we[i] = en[i];
    end

    addr_reg_cell #(.WIDTH(WIDTH), .RST_VAL(RV)) u_cell (
      .clk    (Clock),
      .rst_n  (ResetN),
      .we     (we[i]),
      .funsel (fs),
      .din    (bus.I),
      .q      (q[i]),
      .nxt    (nxt[i]),
      .wrap   (wrap_v[i])
    );
  end

  // A suppressed SP step never commits, so it never reports a wrap either.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wrap_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wrap_q  <= (bus.ClrFlags ? '0 : wrap_q) | (we & wrap_v);
      fault_q <= (bus.ClrFlags ? 1'b0 : fault_q) | sp_fault;
    end
  end

  // Selects beyond NREG-1 match no register and read as zero.
  always_comb begin
    outc = '0;
    outd = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.OutCSel == SELW'(i)) outc = q[i];
      if (bus.OutDSel == SELW'(i)) outd = q[i];
    end
  end

  assign bus.OutC       = outc;
  assign bus.OutD       = outd;
  assign bus.WrapFlag   = wrap_q;
  assign bus.StackFault = fault_q;

endmodule

// File: tb/tb_address_register_file_p.sv
module tb_address_register_file_p;
  import arf_pkg::*;

  logic Clock;
  logic ResetN;

  address_register_file_p_if #(.WIDTH(16), .NREG(3)) ia ();
  address_register_file_p_if #(.WIDTH(32), .NREG(5)) ib ();

  address_register_file_p #(
    .WIDTH(16), .NREG(3), .PC_RST(16'h0000), .SP_RST(16'hFFFF), .STACK_LO(16'hFF00)
  ) dut_a (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (ia)
  );

  address_register_file_p #(
    .WIDTH(32), .NREG(5), .PC_RST(32'h0000_0100), .SP_RST(32'h0001_0000), .STACK_LO(32'h0000_F000)
  ) dut_b (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (ib)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  typedef enum {OC_A, OD_A, WF_A, SF_A, OC_B, OD_B, WF_B, SF_B} obs_e;
  typedef struct {
    obs_e        k;
    logic [31:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   ncomp = 0;
  int   nfail = 0;

  function automatic logic [31:0] obs(input obs_e k);
    case (k)
      OC_A:    return {16'h0, ia.OutC};
      OD_A:    return {16'h0, ia.OutD};
      WF_A:    return {29'h0, ia.WrapFlag};
      SF_A:    return {31'h0, ia.StackFault};
      OC_B:    return ib.OutC;
      OD_B:    return ib.OutD;
      WF_B:    return {27'h0, ib.WrapFlag};
      default: return {31'h0, ib.StackFault};
    endcase
  endfunction

  task automatic push(input obs_e k, input logic [31:0] v, input string tag);
    exp_t e;
    e.k = k; e.v = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_a(input string tag, input logic [15:0] oc, input logic [15:0] od,
                        input logic [2:0] wf, input logic sf);
    push(OC_A, {16'h0, oc}, {tag, ".outc"});
    push(OD_A, {16'h0, od}, {tag, ".outd"});
    push(WF_A, {29'h0, wf}, {tag, ".wrap"});
    push(SF_A, {31'h0, sf}, {tag, ".fault"});
  endtask

  task automatic push_b(input string tag, input logic [31:0] oc, input logic [31:0] od,
                        input logic [4:0] wf, input logic sf);
    push(OC_B, oc, {tag, ".outc"});
    push(OD_B, od, {tag, ".outd"});
    push(WF_B, {27'h0, wf}, {tag, ".wrap"});
    push(SF_B, {31'h0, sf}, {tag, ".fault"});
  endtask

  task automatic check_queue();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.k);
      ncomp++;
      assert (o === e.v) else begin
        nfail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic drv_a(input logic [2:0] rs, input logic [2:0] fs, input logic [15:0] din,
                       input logic [1:0] cs, input logic [1:0] ds, input logic clr);
    ia.RegSel = rs; ia.FunSel = fs; ia.I = din;
    ia.OutCSel = cs; ia.OutDSel = ds; ia.ClrFlags = clr;
  endtask

  task automatic drv_b(input logic [4:0] rs, input logic [2:0] fs, input logic [31:0] din,
                       input logic [2:0] cs, input logic [2:0] ds, input logic clr);
    ib.RegSel = rs; ib.FunSel = fs; ib.I = din;
    ib.OutCSel = cs; ib.OutDSel = ds; ib.ClrFlags = clr;
  endtask

  // Inputs are driven at the falling edge; results are sampled at the next falling edge.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
    check_queue();
  endtask

  initial begin
    ResetN = 1'b0;
    drv_a(3'b111, FS_HOLD, 16'h0, 2'd0, 2'd2, 1'b0);
    drv_b(5'b11111, FS_HOLD, 32'h0, 3'd0, 3'd2, 1'b0);
    @(negedge Clock);
    push_a("rst_a", 16'h0000, 16'hFFFF, 3'b000, 1'b0);
    push_b("rst_b", 32'h0000_0100, 32'h0001_0000, 5'b00000, 1'b0);
    check_queue();
    ResetN = 1'b1;

    // ---------------- 16-bit, 3-register instance ----------------
    drv_a(3'b110, FS_LD,   16'h1234, 2'd0, 2'd1, 1'b0); push_a("ld_pc",      16'h1234, 16'h0000, 3'b000, 1'b0); step();
    drv_a(3'b101, FS_LD,   16'hFFFF, 2'd1, 2'd2, 1'b0); push_a("ld_ar",      16'hFFFF, 16'hFFFF, 3'b000, 1'b0); step();
    drv_a(3'b101, FS_INC2, 16'h0,    2'd1, 2'd1, 1'b0); push_a("ar_inc2",    16'h0001, 16'h0001, 3'b010, 1'b0); step();
    drv_a(3'b101, FS_DEC,  16'h0,    2'd1, 2'd0, 1'b0); push_a("ar_dec",     16'h0000, 16'h1234, 3'b010, 1'b0); step();
    drv_a(3'b101, FS_DEC,  16'h0,    2'd1, 2'd1, 1'b1); push_a("wrap_v_clr", 16'hFFFF, 16'hFFFF, 3'b010, 1'b0); step();
    drv_a(3'b111, FS_LD,   16'h5555, 2'd0, 2'd1, 1'b1); push_a("mask_clr",   16'h1234, 16'hFFFF, 3'b000, 1'b0); step();
    drv_a(3'b011, FS_LD,   16'hFF01, 2'd2, 2'd2, 1'b0); push_a("ld_sp",      16'hFF01, 16'hFF01, 3'b000, 1'b0); step();
    drv_a(3'b011, FS_DEC2, 16'h0,    2'd2, 2'd2, 1'b0); push_a("sp_dec2_lo", 16'hFF01, 16'hFF01, 3'b000, 1'b1); step();
    drv_a(3'b011, FS_DEC,  16'h0,    2'd2, 2'd2, 1'b0); push_a("sp_dec_edge",16'hFF00, 16'hFF00, 3'b000, 1'b1); step();
    drv_a(3'b111, FS_HOLD, 16'h0,    2'd2, 2'd2, 1'b1); push_a("fault_clr",  16'hFF00, 16'hFF00, 3'b000, 1'b0); step();
    drv_a(3'b011, FS_DEC,  16'h0,    2'd2, 2'd2, 1'b0); push_a("sp_dec_lo",  16'hFF00, 16'hFF00, 3'b000, 1'b1); step();
    drv_a(3'b011, FS_LD,   16'hFFFF, 2'd2, 2'd2, 1'b1); push_a("sp_ld_top",  16'hFFFF, 16'hFFFF, 3'b000, 1'b0); step();
    drv_a(3'b011, FS_INC,  16'h0,    2'd2, 2'd2, 1'b0); push_a("sp_inc_hi",  16'hFFFF, 16'hFFFF, 3'b000, 1'b1); step();
    drv_a(3'b011, FS_INC2, 16'h0,    2'd2, 2'd2, 1'b1); push_a("fault_v_clr",16'hFFFF, 16'hFFFF, 3'b000, 1'b1); step();
    drv_a(3'b110, FS_LD,   16'h0000, 2'd0, 2'd2, 1'b1); push_a("ld_pc0",     16'h0000, 16'hFFFF, 3'b000, 1'b0); step();
    drv_a(3'b101, FS_LD,   16'h0005, 2'd1, 2'd0, 1'b0); push_a("ld_ar5",     16'h0005, 16'h0000, 3'b000, 1'b0); step();
    drv_a(3'b000, FS_DEC,  16'h0,    2'd0, 2'd1, 1'b0); push_a("multi_dec",  16'hFFFF, 16'h0004, 3'b001, 1'b0); step();
    drv_a(3'b111, FS_HOLD, 16'h0,    2'd3, 2'd2, 1'b0); push_a("sel_oob",    16'h0000, 16'hFFFE, 3'b001, 1'b0); step();
    drv_a(3'b000, FS_HOLD2,16'h0,    2'd2, 2'd0, 1'b0); push_a("hold_111",   16'hFFFE, 16'hFFFF, 3'b001, 1'b0); step();
    drv_a(3'b000, FS_CLR,  16'h0,    2'd0, 2'd2, 1'b0); push_a("clr_all",    16'h0000, 16'h0000, 3'b001, 1'b0); step();
    drv_a(3'b000, FS_LD,   16'h7777, 2'd0, 2'd2, 1'b0); push_a("ld_all",     16'h7777, 16'h7777, 3'b001, 1'b0); step();

    // Reset asserted while a load is pending: values revert at once, the load never lands.
    drv_a(3'b110, FS_LD, 16'hABCD, 2'd0, 2'd2, 1'b0);
    #2;
    ResetN = 1'b0;
    #1;
    push_a("rst_mid", 16'h0000, 16'hFFFF, 3'b000, 1'b0);
    check_queue();
    @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    drv_a(3'b111, FS_HOLD, 16'h0, 2'd0, 2'd2, 1'b0); push_a("rst_discard", 16'h0000, 16'hFFFF, 3'b000, 1'b0); step();

    // ---------------- 32-bit, 5-register instance ----------------
    drv_b(5'b01111, FS_LD,   32'hDEAD_BEEF, 3'd4, 3'd4, 1'b0); push_b("b_ld4",     32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'b00000, 1'b0); step();
    drv_b(5'b10111, FS_LD,   32'hFFFF_FFFF, 3'd3, 3'd3, 1'b0); push_b("b_ld3",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00000, 1'b0); step();
    drv_b(5'b10111, FS_INC2, 32'h0,         3'd3, 3'd5, 1'b0); push_b("b_wrap3",   32'h0000_0001, 32'h0000_0000, 5'b01000, 1'b0); step();
    drv_b(5'b11011, FS_INC,  32'h0,         3'd2, 3'd7, 1'b0); push_b("b_sp_hi",   32'h0001_0000, 32'h0000_0000, 5'b01000, 1'b1); step();
    drv_b(5'b00000, FS_DEC2, 32'h0,         3'd1, 3'd3, 1'b1); push_b("b_multi",   32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'b01010, 1'b0); step();
    drv_b(5'b11111, FS_HOLD, 32'h0,         3'd2, 3'd4, 1'b0); push_b("b_rd_sp",   32'h0000_FFFE, 32'hDEAD_BEED, 5'b01010, 1'b0); step();
    drv_b(5'b11111, FS_HOLD, 32'h0,         3'd0, 3'd6, 1'b0); push_b("b_rd_pc",   32'h0000_00FE, 32'h0000_0000, 5'b01010, 1'b0); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
